cmd_sched: RTL and testbench

Host-side command scheduler for the wireless command link. It queues up to DEPTH command/data pairs and issues them one at a time to the CommMaster UART master. After each command it waits for the copter's response byte and classifies it as accepted, negative, or timed out. Failed commands are retried, and each completion or failure is reported to the requester, which can be bench stimulus or host control logic.

---
 rtl/cmd_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_cmd_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sched.sv
// cmd_sched: queues command/data pairs and issues them one at a time to the UART master,
// classifies each response (accept / negative / timeout) and retries failures up to MAX_RETRY times.
// Latency: a push into an empty idle queue gives snd_cmd two cycles later; one frame outstanding at a time.
module cmd_sched #(
  parameter int         DEPTH       = 4,
  parameter int         TIMEOUT_CYC = 4000000,
  parameter int         MAX_RETRY   = 2,
  parameter logic [7:0] POS_ACK     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_cmd,
  input  logic [15:0]              push_data,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic [7:0]               cmd,
  output logic [15:0]              data,
  output logic                     snd_cmd,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     clr_resp_rdy,
  output logic                     done,
  output logic                     err,
  output logic [7:0]               done_cmd,
  output logic [7:0]               done_resp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [7:0]    REQ_BATT = 8'h01;
  localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMAX     = {TW{1'b1}};
  localparam logic [RW-1:0] RLIMIT   = RW'(MAX_RETRY);
  localparam logic [CW-1:0] CDEPTH   = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CLR,
    RETIRE
  } state_t;

  state_t        state, state_nxt;

  // queue storage and bookkeeping
  logic [7:0]    q_cmd  [DEPTH];
  logic [15:0]   q_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic          pass_q;

  // decisions produced by the FSM for the register processes
  logic          load_cmd;
  logic          retry_inc;
  logic          fin;
  logic          fin_pass;
  logic [7:0]    fin_resp;

  logic          pop;
  logic          push_ok;
  logic          resp_pass;

  assign busy         = (state != IDLE);
  assign full         = (count == CDEPTH);
  assign snd_cmd      = (state == ISSUE);
  assign clr_resp_rdy = (state == CLR);
  assign done         = (state == RETIRE) && pass_q;
  assign err          = (state == RETIRE) && !pass_q;

  // The head entry is only removed when it retires, so every retry re-sends the same pair.
  assign pop       = (state == RETIRE);
  assign push_ok   = push && !full && !flush;
  assign resp_pass = (cmd == REQ_BATT) || (resp == POS_ACK);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the load/retry/finish strobes consumed by the datapath.
  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    retry_inc = 1'b0;
    fin       = 1'b0;
    fin_pass  = 1'b0;
    fin_resp  = 8'h00;
    case (state)
      IDLE: begin
        // a flush in the same cycle empties the queue, so do not start on a stale head
        if ((count != '0) && !flush) begin
          state_nxt = ISSUE;
          load_cmd  = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        // a response arriving in the last allowed cycle still wins over the timeout
        if (resp_rdy) begin
          state_nxt = CLR;
        end else if (timer == TLAST) begin
          if (retry < RLIMIT) begin
            state_nxt = ISSUE;
            retry_inc = 1'b1;
          end else begin
            state_nxt = RETIRE;
            fin       = 1'b1;
            fin_pass  = 1'b0;
            fin_resp  = 8'h00;
          end
        end
      end
      CLR: begin
        if (resp_pass) begin
          state_nxt = RETIRE;
          fin       = 1'b1;
          fin_pass  = 1'b1;
          fin_resp  = resp;
        end else if (retry < RLIMIT) begin
          state_nxt = ISSUE;
          retry_inc = 1'b1;
        end else begin
          state_nxt = RETIRE;
          fin       = 1'b1;
          fin_pass  = 1'b0;
          fin_resp  = resp;
        end
      end
      RETIRE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Queue pointers and occupancy; flush keeps only the in-flight head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // a retiring head is popped even when flushed, leaving the queue empty
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr <= busy ? rd_ptr + AW'(1) : rd_ptr;
      count  <= (busy && !pop) ? CW'(1) : '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // Queue storage write port; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_cmd[wr_ptr]  <= push_cmd;
      q_data[wr_ptr] <= push_data;
    end
  end

  // Response timer: zero outside WAIT, counts up while waiting and saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if ((state == WAIT) && (state_nxt == WAIT)) begin
      if (timer != TMAX) begin
        timer <= timer + TW'(1);
      end
    end else begin
      timer <= '0;
    end
  end

  // Retry counter: bumped on each failed attempt, cleared when the entry retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry <= '0;
    end else if (state == RETIRE) begin
      retry <= '0;
    end else if (retry_inc) begin
      retry <= retry + RW'(1);
    end
  end

  // Outgoing command is latched as the entry starts so it is valid alongside snd_cmd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd  <= 8'h00;
      data <= 16'h0000;
    end else if (load_cmd) begin
      cmd  <= q_cmd[rd_ptr];
      data <= q_data[rd_ptr];
    end
  end

  // Completion record, loaded on entry to RETIRE so it is valid with the done/err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q    <= 1'b0;
      done_cmd  <= 8'h00;
      done_resp <= 8'h00;
    end else if (fin) begin
      pass_q    <= fin_pass;
      done_cmd  <= cmd;
      done_resp <= fin_resp;
    end
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: directed scenarios followed by random batches checked against
// a per-entry outcome model (attempt-by-attempt classification with plain arithmetic).
module tb_cmd_sched;

  localparam int         DEPTH = 4;
  localparam int         TMO   = 200;
  localparam int         MAXR  = 2;
  localparam logic [7:0] ACK   = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [7:0]  push_cmd;
  logic [15:0] push_data;
  logic        flush;
  logic        full;
  logic [2:0]  count;
  logic        busy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        snd_cmd;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        clr_resp_rdy;
  logic        done;
  logic        err;
  logic [7:0]  done_cmd;
  logic [7:0]  done_resp;

  cmd_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .POS_ACK(ACK)) dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_data(push_data),
    .flush(flush), .full(full), .count(count), .busy(busy), .cmd(cmd), .data(data),
    .snd_cmd(snd_cmd), .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
    .done(done), .err(err), .done_cmd(done_cmd), .done_resp(done_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // responder plan, one element per frame: -1 = never answer, else (delay << 8) | byte
  int          plan_q[$];
  // observation logs
  logic [23:0] sent_q[$];
  int          sent_t[$];
  logic [17:0] ret_q[$];
  int          ret_t[$];
  int          clr_n = 0;

  // Record every frame start, clear strobe and retirement seen on the outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (snd_cmd) begin
        sent_q.push_back({cmd, data});
        sent_t.push_back(cyc);
      end
      if (clr_resp_rdy) clr_n++;
      if (done || err) begin
        ret_q.push_back({done, err, done_cmd, done_resp});
        ret_t.push_back(cyc);
      end
    end
  end

  // CommMaster stand-in: answers each frame according to the plan queue.
  initial begin : responder
    int p;
    int d;
    bit abort;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_rdy = 1'b0;
      end else if (snd_cmd) begin
        p = (plan_q.size() != 0) ? plan_q.pop_front() : (256 | 32'hA5);
        if (p >= 0) begin
          d = p >> 8;
          abort = 1'b0;
          for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (rst) abort = 1'b1;
          end
          if (!abort) begin
            resp     = p[7:0];
            resp_rdy = 1'b1;
            for (int i = 0; i < TMO + 10; i++) begin
              @(negedge clk);
              if (rst || clr_resp_rdy) break;
            end
            resp_rdy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    sent_q.delete();
    sent_t.delete();
    ret_q.delete();
    ret_t.delete();
    clr_n = 0;
  endtask

  // One-cycle push, driven between clock edges.
  task automatic do_push(input logic [7:0] c, input logic [15:0] dat);
    push      = 1'b1;
    push_cmd  = c;
    push_data = dat;
    @(negedge clk);
    push      = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!((count == 3'd0) && !busy) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    tick(2);
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  // expected retirement record for a pass / failure
  function automatic logic [17:0] rec(input bit ok, input logic [7:0] c, input logic [7:0] r);
    return {ok, !ok, c, r};
  endfunction

  logic [23:0] exp_sent[$];
  logic [17:0] exp_ret[$];

  initial begin : main
    logic [7:0]  c5 [5];
    logic [7:0]  rc;
    logic [15:0] rd;
    logic [7:0]  r;
    int          p;
    int          att;
    bit          ok;
    bit          fin;
    int          k;

    rst = 1'b1; push = 1'b0; push_cmd = 8'h00; push_data = 16'h0000; flush = 1'b0;
    tick(3);
    chk("reset_outputs", {full, busy, snd_cmd, clr_resp_rdy, done, err, cmd, data}, 32'd0);
    chk("reset_count", count, 0);
    chk("reset_done_rec", {done_cmd, done_resp}, 0);
    rst = 1'b0;
    tick(2);

    // 1: REQ_BATT passes on any byte; push-to-snd_cmd latency is two cycles
    clear_logs();
    plan_q.push_back((3 << 8) | 8'hC0);
    do_push(8'h01, 16'h0000);
    chk("t1_no_snd_n1", snd_cmd, 0);
    chk("t1_count_n1", count, 1);
    tick(1);
    chk("t1_snd_n2", snd_cmd, 1);
    chk("t1_cmd_at_snd", {cmd, data}, {8'h01, 16'h0000});
    wait_idle(500, "t1_idle");
    chk("t1_sends", sent_q.size(), 1);
    chk("t1_clrs", clr_n, 1);
    chk("t1_nret", ret_q.size(), 1);
    if (ret_q.size() > 0) chk("t1_ret", ret_q[0], rec(1, 8'h01, 8'hC0));
    chk("t1_count_end", count, 0);

    // 2: four acked entries back to back, retired in push order
    clear_logs();
    c5[0] = 8'h02; c5[1] = 8'h03; c5[2] = 8'h04; c5[3] = 8'h05;
    for (int i = 0; i < 4; i++) plan_q.push_back((2 << 8) | ACK);
    do_push(c5[0], 16'h003a);
    do_push(c5[1], 16'h003a);
    do_push(c5[2], 16'h800a);
    do_push(c5[3], 16'h00fd);
    wait_idle(500, "t2_idle");
    chk("t2_nret", ret_q.size(), 4);
    chk("t2_nsent", sent_q.size(), 4);
    if (sent_q.size() == 4) begin
      chk("t2_sent0", sent_q[0], {c5[0], 16'h003a});
      chk("t2_sent1", sent_q[1], {c5[1], 16'h003a});
      chk("t2_sent2", sent_q[2], {c5[2], 16'h800a});
      chk("t2_sent3", sent_q[3], {c5[3], 16'h00fd});
      // RETIRE cycle R -> IDLE R+1 -> ISSUE R+2
      if (ret_t.size() > 0) chk("t2_b2b_gap", sent_t[1] - ret_t[0], 2);
    end
    if (ret_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_ret", ret_q[i], rec(1, c5[i], ACK));
    end

    // 3: never answered -> three attempts, each WAIT lasting TMO cycles (spacing TMO+1)
    clear_logs();
    for (int i = 0; i < 3; i++) plan_q.push_back(-1);
    do_push(8'h06, 16'h1234);
    wait_idle(1500, "t3_idle");
    chk("t3_sends", sent_q.size(), 3);
    if (sent_t.size() == 3) begin
      chk("t3_space1", sent_t[1] - sent_t[0], TMO + 1);
      chk("t3_space2", sent_t[2] - sent_t[1], TMO + 1);
      chk("t3_same_frame", sent_q[2], {8'h06, 16'h1234});
    end
    chk("t3_clrs", clr_n, 0);
    if (ret_q.size() == 1) chk("t3_ret", ret_q[0], rec(0, 8'h06, 8'h00));
    else chk("t3_nret", ret_q.size(), 1);

    // 3b: answer lands in the final allowed WAIT cycle -> accepted, no timeout
    clear_logs();
    plan_q.push_back((TMO << 8) | ACK);
    do_push(8'h02, 16'h5555);
    wait_idle(800, "t3b_idle");
    chk("t3b_sends", sent_q.size(), 1);
    if (ret_q.size() == 1) chk("t3b_ret", ret_q[0], rec(1, 8'h02, ACK));
    else chk("t3b_nret", ret_q.size(), 1);

    // 4: negative then positive
    clear_logs();
    plan_q.push_back((4 << 8) | 8'h05);
    plan_q.push_back((4 << 8) | ACK);
    do_push(8'h05, 16'h00fd);
    wait_idle(500, "t4_idle");
    chk("t4_sends", sent_q.size(), 2);
    chk("t4_clrs", clr_n, 2);
    if (ret_q.size() == 1) chk("t4_ret", ret_q[0], rec(1, 8'h05, ACK));
    else chk("t4_nret", ret_q.size(), 1);

    // 5a: five pushes into a 4-deep queue -> fifth dropped
    clear_logs();
    for (int i = 0; i < 5; i++) c5[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 4; i++) plan_q.push_back((2 << 8) | ACK);
    for (int i = 0; i < 5; i++) do_push(c5[i], 16'(i));
    chk("t5_full", full, 1);
    chk("t5_count4", count, 4);
    wait_idle(500, "t5a_idle");
    chk("t5_nret", ret_q.size(), 4);
    if (ret_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t5_ret", ret_q[i], rec(1, c5[i], ACK));
    end

    // 5b: flush (with a simultaneous push) during WAIT keeps only the in-flight head
    clear_logs();
    plan_q.push_back((60 << 8) | ACK);
    do_push(8'h21, 16'h0001);
    do_push(8'h22, 16'h0002);
    do_push(8'h23, 16'h0003);
    tick(10);
    flush = 1'b1; push = 1'b1; push_cmd = 8'h24; push_data = 16'h0004;
    @(negedge clk);
    flush = 1'b0; push = 1'b0;
    chk("t5_flush_count", count, 1);
    chk("t5_flush_busy", busy, 1);
    wait_idle(500, "t5b_idle");
    chk("t5b_sends", sent_q.size(), 1);
    if (ret_q.size() == 1) chk("t5b_ret", ret_q[0], rec(1, 8'h21, ACK));
    else chk("t5b_nret", ret_q.size(), 1);
    chk("t5b_busy_end", busy, 0);

    // 6: reset in the middle of WAIT
    clear_logs();
    plan_q.push_back(-1);
    do_push(8'h07, 16'habcd);
    tick(22);
    chk("t6_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {full, busy, snd_cmd, clr_resp_rdy, done, err, cmd, data}, 32'd0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_done_rec", {done_cmd, done_resp}, 0);
    @(negedge clk);
    rst = 1'b0;
    plan_q.delete();
    tick(1);
    clear_logs();
    plan_q.push_back((2 << 8) | ACK);
    do_push(8'h08, 16'h0001);
    tick(1);
    chk("t6_snd_after_rst", snd_cmd, 1);
    wait_idle(500, "t6_idle");
    chk("t6_clrs", clr_n, 1);
    if (ret_q.size() == 1) chk("t6_ret", ret_q[0], rec(1, 8'h08, ACK));
    else chk("t6_nret", ret_q.size(), 1);

    // random batches against the outcome model
    for (int b = 0; b < 8; b++) begin
      clear_logs();
      exp_sent.delete();
      exp_ret.delete();
      k = $urandom_range(1, DEPTH);
      for (int e = 0; e < k; e++) begin
        rc = 8'($urandom_range(0, 7));
        rd = 16'($urandom);
        att = 0;
        fin = 1'b0;
        ok  = 1'b0;
        r   = 8'h00;
        while (!fin) begin
          case ($urandom_range(0, 9))
            0:       p = -1;
            1, 2, 3: p = ($urandom_range(1, 30) << 8) | $urandom_range(0, 255);
            4:       p = (TMO << 8) | ACK;
            default: p = ($urandom_range(1, 30) << 8) | ACK;
          endcase
          plan_q.push_back(p);
          exp_sent.push_back({rc, rd});
          att++;
          r  = (p < 0) ? 8'h00 : p[7:0];
          ok = (p >= 0) && ((rc == 8'h01) || (r == ACK));
          if (ok || (att == MAXR + 1)) fin = 1'b1;
        end
        exp_ret.push_back(rec(ok, rc, r));
        push = 1'b1; push_cmd = rc; push_data = rd;
        @(negedge clk);
      end
      push = 1'b0;
      wait_idle(8000, "rnd_idle");
      chk("rnd_nsent", sent_q.size(), exp_sent.size());
      chk("rnd_nret", ret_q.size(), exp_ret.size());
      if (sent_q.size() == exp_sent.size())
        foreach (exp_sent[i]) chk("rnd_sent", sent_q[i], exp_sent[i]);
      if (ret_q.size() == exp_ret.size())
        foreach (exp_ret[i]) chk("rnd_ret", ret_q[i], exp_ret[i]);
      plan_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
